// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared parameters, pointer type and flag compare functions
//
// Purpose: defaults and helpers shared by the single-clock FIFO and its storage.
// Pointers are compared zero-extended to PTR_W_MAX bits so one pair of functions
// serves any ASIZE below PTR_W_MAX.
package async_fifo_pkg;

  localparam int DSIZE_DEF = 32;
  localparam int ASIZE_DEF = 4;
  localparam int PTR_W_MAX = 17;

  // Default-geometry pointer: ASIZE address bits plus one wrap bit.
  typedef logic [ASIZE_DEF:0] ptr_t;

  // Equal pointers, wrap bit included, mean no words are held.
  function automatic logic ptr_empty(input logic [PTR_W_MAX-1:0] wptr,
                                     input logic [PTR_W_MAX-1:0] rptr);
    return (wptr == rptr);
  endfunction

  // Full when only the wrap bit differs: the XOR of the pointers is exactly 1 << asize.
  function automatic logic ptr_full(input logic [PTR_W_MAX-1:0] wptr,
                                    input logic [PTR_W_MAX-1:0] rptr,
                                    input int unsigned          asize);
    logic [PTR_W_MAX-1:0] wrap_bit;
    wrap_bit = PTR_W_MAX'(1) << asize;
    return ((wptr ^ rptr) == wrap_bit);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// rtl/async_fifo_mem.sv - simple dual-port array, synchronous write, asynchronous read
//
// Ports:
//   clk    in  clock for the write port
//   we     in  write enable
//   waddr  in  write address (ASIZE bits)
//   wdata  in  write data (DSIZE bits)
//   raddr  in  read address (ASIZE bits)
//   rdata  out combinational read data (DSIZE bits)
// Contents are never reset.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/async_fifo_1clk.sv
// rtl/async_fifo_1clk.sv - single-clock show-ahead FIFO with the async_fifo port set
//
// Ports:
//   clk    in  sole clock
//   rst    in  synchronous active-high reset
//   winc   in  write request
//   wdata  in  write data (DSIZE bits)
//   wfull  out registered full flag
//   rinc   in  read/pop request
//   rdata  out head-of-FIFO word, valid while rempty is low
//   rempty out registered empty flag
// Optional macro ASYNC_FIFO_ASSERT_EN adds simulation-only overflow, underflow
// and flag-consistency checks; datapath behaviour is the same either way.
module async_fifo_1clk
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic           wfull_q, rempty_q;
  logic           do_write, do_read;

  // Each side is qualified only by its own registered flag, so a simultaneous
  // push and pop on a full FIFO pops only, and on an empty FIFO pushes only.
  assign do_write = winc && !wfull_q;
  assign do_read  = rinc && !rempty_q;

  always_comb begin
    wptr_d = wptr_q + {{ASIZE{1'b0}}, do_write};
    rptr_d = rptr_q + {{ASIZE{1'b0}}, do_read};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      wfull_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      // Flags come from the next-state pointers so they are correct in the
      // cycle right after the edge that changed occupancy.
      rempty_q <= ptr_empty(PTR_W_MAX'(wptr_d), PTR_W_MAX'(rptr_d));
      wfull_q  <= ptr_full(PTR_W_MAX'(wptr_d), PTR_W_MAX'(rptr_d), ASIZE);
    end
  end

  // A write attempted in the reset cycle must not touch the array.
  async_fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk  (clk),
    .we   (do_write && !rst),
    .waddr(wptr_q[ASIZE-1:0]),
    .wdata(wdata),
    .raddr(rptr_q[ASIZE-1:0]),
    .rdata(rdata)
  );

  assign wfull  = wfull_q;
  assign rempty = rempty_q;

`ifdef ASYNC_FIFO_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(winc && wfull_q))
        else $error("async_fifo_1clk: write attempted while full");
      assert (!(rinc && rempty_q))
        else $error("async_fifo_1clk: read attempted while empty");
      assert (!(wfull_q && rempty_q))
        else $error("async_fifo_1clk: full and empty both set");
    end
  end
`else
`endif

endmodule

// File: tb/tb_async_fifo_1clk.sv
// tb/tb_async_fifo_1clk.sv - directed self-checking bench for async_fifo_1clk
module tb_async_fifo_1clk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        winc = 1'b0;
  logic [31:0] wdata = '0;
  logic        wfull;
  logic        rinc = 1'b0;
  logic [31:0] rdata;
  logic        rempty;

  int checks = 0;
  int errors = 0;

  async_fifo_1clk #(.DSIZE(32), .ASIZE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .winc  (winc),
    .wdata (wdata),
    .wfull (wfull),
    .rinc  (rinc),
    .rdata (rdata),
    .rempty(rempty)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    winc = 1'b1; wdata = d;
    tick();
    winc = 1'b0;
  endtask

  task automatic pop();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (wfull !== 1'b0 || rempty !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc %0d wfull=%b rempty=%b want 0/1", i, wfull, rempty);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (wfull !== 1'b0 || rempty !== 1'b1) begin
        errors++;
        $display("FAIL idle cyc %0d wfull=%b rempty=%b want 0/1", i, wfull, rempty);
      end
    end
  endtask

  task automatic test_single();
    push(32'h0000_000A);
    checks++;
    if (rempty !== 1'b0) begin
      errors++; $display("FAIL single_rempty got %b want 0", rempty);
    end
    checks++;
    if (rdata !== 32'h0000_000A) begin
      errors++; $display("FAIL single_rdata got %h want 0000000a", rdata);
    end
    pop();
    checks++;
    if (rempty !== 1'b1) begin
      errors++; $display("FAIL single_pop_rempty got %b want 1", rempty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      int waited;
      push(32'(i));
      waited = 0;
      while (rempty !== 1'b0 && waited < 10) begin
        tick();
        waited++;
      end
      checks++;
      if (rempty !== 1'b0) begin
        errors++; $display("FAIL wrap_timeout iter %0d rempty stuck at %b", i, rempty);
      end else if (rdata !== 32'(i)) begin
        errors++; $display("FAIL wrap_data iter %0d got %h want %h", i, rdata, 32'(i));
      end
      pop();
    end
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++; $display("FAIL wrap_end rempty=%b wfull=%b want 1/0", rempty, wfull);
    end
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      push(32'(i));
      checks++;
      if (wfull !== (i == 15)) begin
        errors++; $display("FAIL fill_wfull after write %0d got %b want %b", i, wfull, (i == 15));
      end
    end
  endtask

  task automatic drain_expect(input int first);
    for (int i = first; i < 16; i++) begin
      checks++;
      if (rempty !== 1'b0 || rdata !== 32'(i)) begin
        errors++; $display("FAIL drain_word %0d got %h rempty=%b want %h/0", i, rdata, rempty, 32'(i));
      end
      pop();
    end
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++; $display("FAIL drain_end rempty=%b wfull=%b want 1/0", rempty, wfull);
    end
  endtask

  task automatic test_full();
    fill16();
    push(32'h0000_DEAD);
    checks++;
    if (wfull !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL overflow_drop wfull=%b head=%h want 1/00000000", wfull, rdata);
    end
    pop();
    checks++;
    if (wfull !== 1'b0) begin
      errors++; $display("FAIL one_read_clears_full got %b want 0", wfull);
    end
    drain_expect(1);
  endtask

  task automatic test_simultaneous();
    fill16();
    winc = 1'b1; rinc = 1'b1; wdata = 32'h55;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++;
    if (wfull !== 1'b0 || rdata !== 32'd1) begin
      errors++; $display("FAIL simul_full wfull=%b head=%h want 0/00000001", wfull, rdata);
    end
    drain_expect(1);
    // Both requests on an empty FIFO: only the write takes effect.
    winc = 1'b1; rinc = 1'b1; wdata = 32'h33;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++;
    if (rempty !== 1'b0 || rdata !== 32'h33) begin
      errors++; $display("FAIL simul_empty rempty=%b head=%h want 0/00000033", rempty, rdata);
    end
    // Mid-level: push and pop together keep one entry, head moves to the new word.
    winc = 1'b1; rinc = 1'b1; wdata = 32'h44;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++;
    if (rempty !== 1'b0 || rdata !== 32'h44) begin
      errors++; $display("FAIL simul_mid rempty=%b head=%h want 0/00000044", rempty, rdata);
    end
    pop();
    checks++;
    if (rempty !== 1'b1) begin
      errors++; $display("FAIL simul_mid_pop rempty=%b want 1", rempty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++; $display("FAIL mid_reset rempty=%b wfull=%b want 1/0", rempty, wfull);
    end
    push(32'h77);
    checks++;
    if (rempty !== 1'b0 || rdata !== 32'h77) begin
      errors++; $display("FAIL post_reset_data rempty=%b head=%h want 0/00000077", rempty, rdata);
    end
    pop();
    checks++;
    if (rempty !== 1'b1) begin
      errors++; $display("FAIL post_reset_pop rempty=%b want 1", rempty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_full();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
